// File: rtl/demux16_write_32.sv
// Sixteen-entry register file with a one-hot write demux and a burst engine.
// A first beat writes the entry selected by wr_sel. A burst then continues
// writing successive entries, wrapping from 15 to 0, until its count runs out.
module demux16_write_32 #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [3:0]        wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_burst,
  input  logic [4:0]        burst_len,
  output logic [DATA_W-1:0] q0,
  output logic [DATA_W-1:0] q1,
  output logic [DATA_W-1:0] q2,
  output logic [DATA_W-1:0] q3,
  output logic [DATA_W-1:0] q4,
  output logic [DATA_W-1:0] q5,
  output logic [DATA_W-1:0] q6,
  output logic [DATA_W-1:0] q7,
  output logic [DATA_W-1:0] q8,
  output logic [DATA_W-1:0] q9,
  output logic [DATA_W-1:0] q10,
  output logic [DATA_W-1:0] q11,
  output logic [DATA_W-1:0] q12,
  output logic [DATA_W-1:0] q13,
  output logic [DATA_W-1:0] q14,
  output logic [DATA_W-1:0] q15,
  output logic [15:0]       we_onehot,
  output logic              busy,
  output logic              done
);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e            state_q;
  logic [3:0]        addr_q;
  logic [4:0]        cnt_q;
  logic [DATA_W-1:0] mem_q [16];

  logic [4:0] len_sat;
  logic       start_burst;

  // Lengths above 16 can never cover more than the whole file once.
  assign len_sat     = (burst_len > 5'd16) ? 5'd16 : burst_len;
  assign start_burst = wr_burst && (len_sat >= 5'd2);

  assign wr_ready = ~clr;
  assign busy     = (state_q == StBurst);

  assign q0  = mem_q[0];
  assign q1  = mem_q[1];
  assign q2  = mem_q[2];
  assign q3  = mem_q[3];
  assign q4  = mem_q[4];
  assign q5  = mem_q[5];
  assign q6  = mem_q[6];
  assign q7  = mem_q[7];
  assign q8  = mem_q[8];
  assign q9  = mem_q[9];
  assign q10 = mem_q[10];
  assign q11 = mem_q[11];
  assign q12 = mem_q[12];
  assign q13 = mem_q[13];
  assign q14 = mem_q[14];
  assign q15 = mem_q[15];

  // Burst FSM, entry storage and registered write/done markers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      addr_q    <= 4'd0;
      cnt_q     <= 5'd0;
      we_onehot <= 16'h0000;
      done      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr) begin
      // wr_ready is low, so the offered beat is dropped along with any burst.
      state_q   <= StIdle;
      addr_q    <= 4'd0;
      cnt_q     <= 5'd0;
      we_onehot <= 16'h0000;
      done      <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      we_onehot <= 16'h0000;
      done      <= 1'b0;
      if (wr_valid) begin
        case (state_q)
          StIdle: begin
            mem_q[wr_sel] <= wr_data;
            we_onehot     <= 16'h0001 << wr_sel;
            if (start_burst) begin
              addr_q  <= wr_sel + 4'd1;
              cnt_q   <= len_sat - 5'd1;
              state_q <= StBurst;
            end else begin
              done <= 1'b1;
            end
          end
          StBurst: begin
            mem_q[addr_q] <= wr_data;
            we_onehot     <= 16'h0001 << addr_q;
            addr_q        <= addr_q + 4'd1;
            cnt_q         <= cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
              state_q <= StIdle;
              done    <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/demux16_write_32.md
DEMUX16_WRITE_32 -- requirements
Module: demux16_write_32

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of each storage entry and of wr_data.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port clr, input, 1 bit: synchronous clear of all entries and abort of any burst.
REQ-005 The block SHALL have port wr_valid, input, 1 bit: a write beat is offered.
REQ-006 The block SHALL have port wr_ready, output, 1 bit: the block accepts the offered beat this cycle.
REQ-007 The block SHALL have port wr_sel, input, 4 bits: target entry index, sampled only on the first beat.
REQ-008 The block SHALL have port wr_data, input, DATA_W bits: beat data.
REQ-009 The block SHALL have port wr_burst, input, 1 bit: the first beat starts a burst.
REQ-010 The block SHALL have port burst_len, input, 5 bits: total beats in a burst, sampled on the first beat.
REQ-011 The block SHALL have ports q0..q15, outputs, DATA_W bits each: registered entry contents.
REQ-012 The block SHALL have port we_onehot, output, 16 bits: registered one-hot marker of the entry written at the previous edge.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in state BURST.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse after the final beat of a transfer.

Function
REQ-015 A beat SHALL be accepted at a rising edge when wr_valid=1, wr_ready=1 and clr=0.
REQ-016 wr_ready SHALL equal NOT clr, combinationally, in both states.
REQ-017 The state machine SHALL have exactly two states, IDLE and BURST.
REQ-018 In IDLE, an accepted beat SHALL write wr_data into entry wr_sel at that edge; there is no other write latency.
REQ-019 In IDLE, an accepted beat with wr_burst=0, or with wr_burst=1 and burst_len in {0,1}, SHALL be a single write: the state stays IDLE and done pulses in the following cycle.
REQ-020 In IDLE, an accepted beat with wr_burst=1 and burst_len>=2 SHALL set the address register to wr_sel+1 (mod 16) and the remaining count to burst_len-1, then enter BURST.
REQ-021 burst_len values 17..31 SHALL saturate to 16.
REQ-022 In BURST, each accepted beat SHALL write the address-register entry, increment the address mod 16 (15 wraps to 0) and decrement the remaining count.
REQ-023 In BURST, wr_sel, wr_burst and burst_len SHALL be ignored.
REQ-024 In BURST, a cycle with wr_valid=0 SHALL hold all state and write nothing.
REQ-025 The beat that takes the remaining count to 0 SHALL return the state to IDLE and pulse done in the following cycle.
REQ-026 we_onehot SHALL equal (1 << index written) for exactly one cycle after each write, and 0 otherwise.
REQ-027 clr=1 SHALL, at the edge, zero q0..q15, force IDLE, zero the count, and suppress that cycle's write, done pulse and we_onehot marker.
REQ-028 A write to an entry SHALL leave all other entries unchanged.

Reset
REQ-029 While reset_n=0, regardless of clk, q0..q15, we_onehot, busy, done, the address and the count SHALL all be 0, and the state SHALL be IDLE.
REQ-030 Assertion of reset_n=0 mid-burst SHALL abort the burst with no partial-state retention.
REQ-031 Operation SHALL resume at the first rising edge after reset_n returns to 1.

Verification
REQ-032 Single write: reset, then wr_sel=5, wr_data=0xDEADBEEF, one valid cycle -> q5=0xDEADBEEF, we_onehot=0x0020 and done=1 for one cycle, all other q=0.
REQ-033 Burst with wrap: wr_sel=14, burst_len=4, data 1,2,3,4 -> q14=1, q15=2, q0=3, q1=4; busy high for 3 cycles; done once after the 4th beat.
REQ-034 Stalled burst: burst_len=3 with wr_valid low for 2 cycles between beats -> no writes during the stall; the final contents match an unstalled run.
REQ-035 burst_len=0 and burst_len=20 at wr_sel=0 -> the first case is a single write to q0; the second writes all 16 entries and then returns to IDLE.
REQ-036 clr mid-burst (after 2 of 5 beats) -> all q=0, busy=0, wr_ready=0 in the clr cycle, no done pulse; the next beat is treated as a new first beat.
REQ-037 reset_n pulsed low between clock edges mid-burst -> all outputs 0 immediately, without waiting for a clock edge.
